// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch buffer.
package ifu_pkg;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ibuf_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/ifu_sync_fifo.sv
// ifu_sync_fifo: power-of-two synchronous FIFO with flush and a head view taken from registered storage.
module ifu_sync_fifo #(
    parameter int DEPTH = 4,
    parameter type entry_t = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  entry_t                   din_i,
    output entry_t                   head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & (count_q != '0) & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifu_ibuf.sv
// ifu_ibuf: single-outstanding fetch sequencer with slot reservation, redirect flush and an in-order instruction buffer.
module ifu_ibuf
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = ifu_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifetch_inst_vld,
    input  logic [63:0] ifetch_inst_pc,
    input  logic [63:0] ifetch_inst,
    output logic        ifetch_req,
    output logic        ifetch_taken,
    output logic [63:0] ifetch_taken_pc,
    input  logic        redirect_vld,
    input  logic [63:0] redirect_pc,
    output logic        ibuf_vld,
    output logic [63:0] ibuf_pc,
    output logic [31:0] ibuf_inst,
    input  logic        decode_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t   state_q, state_d;
    logic           pend_q, pend_d;
    logic [63:0]    pend_pc_q, pend_pc_d;
    logic [CW-1:0]  count;
    logic           push;
    ibuf_entry_t    head;
    logic           unused_inst_hi;

    assign unused_inst_hi = ^ifetch_inst[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BUSY;
            pend_q    <= 1'b0;
            pend_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    // A sequential fetch is only issued with a free slot, so a response can always be pushed.
    always_comb begin
        state_d         = state_q;
        pend_d          = pend_q;
        pend_pc_d       = pend_pc_q;
        ifetch_req      = 1'b0;
        ifetch_taken    = 1'b0;
        push            = 1'b0;
        ifetch_taken_pc = redirect_vld ? redirect_pc : pend_pc_q;
        case (state_q)
            IDLE: begin
                if (pend_q || redirect_vld) begin
                    ifetch_req   = 1'b1;
                    ifetch_taken = 1'b1;
                    pend_d       = 1'b0;
                    state_d      = BUSY;
                end else if (count != CW'(DEPTH)) begin
                    ifetch_req = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (redirect_vld) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                    state_d   = ifetch_inst_vld ? IDLE : DROP;
                end else if (ifetch_inst_vld) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (redirect_vld) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_pc;
                end
                if (ifetch_inst_vld) state_d = IDLE;
            end
            default: state_d = BUSY;
        endcase
    end

    ifu_sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (ibuf_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (ibuf_vld & decode_ready),
        .flush_i (redirect_vld),
        .din_i   ('{pc: ifetch_inst_pc, inst: ifetch_inst[31:0]}),
        .head_o  (head),
        .count_o (count)
    );

    assign ibuf_vld  = count != '0;
    assign ibuf_pc   = head.pc;
    assign ibuf_inst = head.inst;

endmodule

// File: doc/ifu_ibuf.md
IFU_IBUF -- requirements
Module: ifu_ibuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 64'h80000000, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ifetch_inst_vld  in  1  fetch response valid, one-cycle pulse.
REQ-006 SHALL have port ifetch_inst_pc  in  64  PC of the fetch response.
REQ-007 SHALL have port ifetch_inst  in  64  response word; only bits [31:0] used.
REQ-008 SHALL have port ifetch_req  out  1  one-cycle fetch issue pulse.
REQ-009 SHALL have port ifetch_taken  out  1  with ifetch_req: fetch from ifetch_taken_pc instead of pc+4.
REQ-010 SHALL have port ifetch_taken_pc  out  64  redirect target.
REQ-011 SHALL have port redirect_vld  in  1  flush plus redirect from execute, one-cycle pulse.
REQ-012 SHALL have port redirect_pc  in  64  redirect target.
REQ-013 SHALL have port ibuf_vld  out  1  head entry valid to decode.
REQ-014 SHALL have port ibuf_pc  out  64  head entry PC.
REQ-015 SHALL have port ibuf_inst  out  32  head entry instruction.
REQ-016 SHALL have port decode_ready  in  1  decode accepts the head; a pop occurs on ibuf_vld & decode_ready.

Function
REQ-017 SHALL keep at most one fetch outstanding, using fetch FSM states IDLE, BUSY and DROP.
REQ-018 In IDLE with pending redirect or redirect_vld, SHALL assert ifetch_req=1 and ifetch_taken=1, go to BUSY, and clear pending. ifetch_taken_pc is redirect_pc if redirect_vld, else the pending PC.
REQ-019 In IDLE with no redirect and count<DEPTH, SHALL assert ifetch_req=1 and ifetch_taken=0, then go to BUSY. This issue reserves one slot.
REQ-020 In BUSY on ifetch_inst_vld without redirect_vld, SHALL push {ifetch_inst_pc, ifetch_inst[31:0]} and go to IDLE.
REQ-021 In BUSY on redirect_vld without ifetch_inst_vld, SHALL latch redirect_pc as pending and go to DROP.
REQ-022 In BUSY on redirect_vld and ifetch_inst_vld together, SHALL discard the response, latch pending and go to IDLE.
REQ-023 In DROP, SHALL discard ifetch_inst_vld and go to IDLE. A further redirect_vld in DROP overwrites the pending PC.
REQ-024 ifetch_req, ifetch_taken and ifetch_taken_pc SHALL be combinational from state, pending, count and redirect inputs. ifetch_taken and ifetch_taken_pc are don't-care when ifetch_req=0.
REQ-025 redirect_vld SHALL clear count and both pointers in the same edge. A pop in that cycle is ignored and a push in that cycle is suppressed.
REQ-026 Push-to-visible latency SHALL be 1 cycle: data pushed at edge N appears on ibuf_* after edge N.
REQ-027 On simultaneous push and pop, count SHALL be unchanged. A push never occurs when full, because of the reservation.
REQ-028 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH. count SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-029 ibuf_vld SHALL equal (count!=0). ibuf_pc and ibuf_inst are don't-care when ibuf_vld=0.
REQ-030 ifetch_inst_vld in IDLE SHALL be ignored (protocol error); the bench flags it as an error.

Reset
REQ-031 On rst, state SHALL be BUSY, since the fetch unit self-issues the RESET_PC fetch with no request.
REQ-032 On rst, count, pointers and pending SHALL be 0 and the pending PC SHALL be RESET_PC.
REQ-033 During rst and on the first cycle after it, ibuf_vld=0 and ifetch_req=0.
REQ-034 rst asserted mid-operation SHALL discard all entries and any outstanding or pending fetch, with no partial push.

Structure
REQ-035 Package ifu_pkg SHALL hold RESET_PC, ibuf_entry_t {pc[63:0], inst[31:0]} and the fetch_state_t enum {IDLE, BUSY, DROP}.
REQ-036 Storage SHALL be one sub-module, ifu_sync_fifo: parameterised DEPTH and entry type, with push, pop, flush, count, and a registered head.
REQ-037 FSM, reservation logic and redirect handling SHALL reside in ifu_ibuf.

Verification
REQ-038 Reset scenario: rst, then response pc=0x80000000 inst=0x00000413 -> ibuf_vld=1 next cycle with that pc/inst, and ifetch_req=1 with taken=0.
REQ-039 Backpressure scenario: decode_ready=0 and in-order responses 0x80000000..0x8000000C -> count=4, ifetch_req held 0. One pop -> ifetch_req=1 the next cycle.
REQ-040 Redirect while BUSY: redirect_pc=0x80001000, then response pc=0x80000010 -> response dropped, ibuf_vld=0. Next cycle ifetch_req=1, taken=1, taken_pc=0x80001000.
REQ-041 Redirect coinciding with response: redirect_vld and ifetch_inst_vld in the same cycle -> buffer empty and state IDLE. Next cycle taken fetch of redirect_pc.
REQ-042 Double redirect in DROP: 0x80002000 then 0x80003000 -> the single taken fetch after the drop uses 0x80003000.
REQ-043 Full with simultaneous pop and redirect: count=4, pop and redirect in the same cycle -> count=0 and no duplicate pop is observed.
